// File: rtl/us_dac_pkg.sv
// Shared state encoding, serial frame-format constants and parameter-legality helpers
// for the ultrasound tone-burst DAC driver.
package us_dac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadAddr,
        StLoadData,
        StFrame,
        StGap,
        StFinalFrame,
        StFinalGap
    } dac_state_e;

    // Zero bits ahead of the sample in every serial frame.
    localparam int unsigned LeadPad = 2;

    function automatic int unsigned trail_pad(input int unsigned frame_w, input int unsigned dac_w);
        return frame_w - dac_w - LeadPad;
    endfunction

    function automatic int unsigned midscale(input int unsigned dac_w);
        return 32'd1 << (dac_w - 1);
    endfunction

    function automatic bit params_ok(input int unsigned dac_w, input int unsigned frame_w,
                                     input int unsigned phase_w, input int unsigned lut_aw,
                                     input int unsigned clk_div, input int unsigned sync_idle,
                                     input int unsigned cnt_w);
        return (dac_w >= 2) && (dac_w <= 31) && (frame_w >= dac_w + LeadPad) &&
               (lut_aw >= 3) && (phase_w >= lut_aw) && (clk_div >= 1) &&
               (sync_idle >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/sine_lut_qw.sv
// Quarter-wave sine ROM with quadrant mirroring/negation; signed output registered,
// so the sample for an address appears one cycle later.
module sine_lut_qw
    import us_dac_pkg::*;
#(
    parameter int unsigned DAC_W  = 12,
    parameter int unsigned LUT_AW = 8
) (
    input  logic                    i_clk,
    input  logic [LUT_AW-1:0]       i_addr,
    output logic signed [DAC_W-1:0] o_sine
);
    localparam int unsigned QW = LUT_AW - 2;
    localparam int unsigned QN = 2 ** QW;

    // Elaboration-only: rounded full-scale sine of quarter-wave entry idx (Taylor series).
    function automatic int sin_round(input int unsigned idx);
        real x;
        real term;
        real acc;
        x    = 3.14159265358979323846 / 2.0 * real'(idx) / real'(QN);
        term = x;
        acc  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return $rtoi(acc * real'((2 ** (DAC_W - 1)) - 1) + 0.5);
    endfunction

    logic [DAC_W-2:0] w_rom [QN+1];

    for (genvar g = 0; g <= QN; g++) begin : g_rom
        assign w_rom[g] = (DAC_W - 1)'(sin_round(g));
    end

    logic [1:0]             w_quad;
    logic [QW-1:0]          w_idx;
    logic [QW:0]            w_ridx;
    logic [DAC_W-2:0]       w_mag;
    logic signed [DAC_W-1:0] r_sine;

    assign w_quad = i_addr[LUT_AW-1 -: 2];
    assign w_idx  = i_addr[QW-1:0];
    assign w_ridx = w_quad[0] ? ((QW + 1)'(QN) - {1'b0, w_idx}) : {1'b0, w_idx};
    assign w_mag  = w_rom[w_ridx];

    always_ff @(posedge i_clk) begin
        r_sine <= w_quad[1] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

    assign o_sine = r_sine;

endmodule

// File: rtl/us_burst_dac_drv.sv
// Tone-burst DDS driving a serial offset-binary DAC: n_cycles sine periods followed by one
// midscale frame so the transducer drive parks at zero.
module us_burst_dac_drv
    import us_dac_pkg::*;
#(
    parameter int unsigned DAC_W     = 12,
    parameter int unsigned FRAME_W   = 16,
    parameter int unsigned PHASE_W   = 24,
    parameter int unsigned LUT_AW    = 8,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned SYNC_IDLE = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [PHASE_W-1:0] i_freq_word,
    input  logic [CNT_W-1:0]   i_n_cycles,
    input  logic [2:0]         i_amp_shift,
    output logic               o_clk_out,
    output logic               o_sync_out,
    output logic               o_din,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned BitLen = 2 * CLK_DIV;
    localparam int unsigned GapLen = SYNC_IDLE * BitLen;
    localparam int unsigned CtrW   = $clog2(GapLen + 1);
    localparam int unsigned BitW   = $clog2(FRAME_W);
    localparam int unsigned TrailW = trail_pad(FRAME_W, DAC_W);
    localparam logic [DAC_W-1:0]   Mid     = DAC_W'(midscale(DAC_W));
    localparam logic [FRAME_W-1:0] MidWord = FRAME_W'(Mid) << TrailW;

    if (!params_ok(DAC_W, FRAME_W, PHASE_W, LUT_AW, CLK_DIV, SYNC_IDLE, CNT_W)) begin : g_param_chk
        $error("us_burst_dac_drv: illegal parameter combination");
    end

    dac_state_e          r_state;
    logic [PHASE_W-1:0]  r_freq;
    logic [CNT_W-1:0]    r_ncyc;
    logic [2:0]          r_amp;
    logic [PHASE_W-1:0]  r_phase;
    logic [CNT_W-1:0]    r_cyc;
    logic                r_stop;
    logic                r_last;
    logic [FRAME_W-1:0]  r_sreg;
    logic [CtrW-1:0]     r_cnt;
    logic [BitW-1:0]     r_bit;
    logic                r_clk_out;
    logic                r_sync;
    logic                r_din;
    logic                r_busy;
    logic                r_done;

    logic signed [DAC_W-1:0] w_lut;
    logic signed [DAC_W-1:0] w_scaled;
    logic [DAC_W-1:0]        w_sample;
    logic [FRAME_W-1:0]      w_word;
    logic [PHASE_W:0]        w_phase_sum;
    logic [CNT_W-1:0]        w_cyc_next;
    logic                    w_gap_end;
    logic                    w_load;
    logic                    w_final;

    sine_lut_qw #(
        .DAC_W (DAC_W),
        .LUT_AW(LUT_AW)
    ) u_lut (
        .i_clk (i_clk),
        .i_addr(r_phase[PHASE_W-1 -: LUT_AW]),
        .o_sine(w_lut)
    );

    assign w_scaled    = w_lut >>> r_amp;
    assign w_sample    = Mid + $unsigned(w_scaled);
    assign w_final     = r_last || r_stop;
    assign w_word      = w_final ? MidWord : (FRAME_W'(w_sample) << TrailW);
    assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_freq};
    assign w_cyc_next  = r_cyc + CNT_W'(w_phase_sum[PHASE_W]);
    assign w_gap_end   = (r_cnt == CtrW'(GapLen - 1));
    assign w_load      = (r_state == StLoadData) || ((r_state == StGap) && w_gap_end);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_freq    <= '0;
            r_ncyc    <= '0;
            r_amp     <= '0;
            r_phase   <= '0;
            r_cyc     <= '0;
            r_stop    <= 1'b0;
            r_last    <= 1'b0;
            r_sreg    <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_clk_out <= 1'b0;
            r_sync    <= 1'b1;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy && i_stop && !(r_state inside {StFinalFrame, StFinalGap})) begin
                r_stop <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (i_start && !r_done) begin
                        r_freq  <= i_freq_word;
                        r_ncyc  <= i_n_cycles;
                        r_amp   <= i_amp_shift;
                        r_phase <= '0;
                        r_cyc   <= '0;
                        r_stop  <= 1'b0;
                        r_last  <= (i_n_cycles == '0);
                        r_busy  <= 1'b1;
                        r_state <= StLoadAddr;
                    end
                end
                StLoadAddr: r_state <= StLoadData;
                StLoadData, StGap: begin
                    if (w_load) begin
                        r_state   <= w_final ? StFinalFrame : StFrame;
                        r_sreg    <= w_word << 1;
                        r_din     <= w_word[FRAME_W-1];
                        r_sync    <= 1'b0;
                        r_clk_out <= 1'b1;
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        if (!w_final) begin
                            r_phase <= w_phase_sum[PHASE_W-1:0];
                            r_cyc   <= w_cyc_next;
                            r_last  <= (w_cyc_next == r_ncyc);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StFrame, StFinalFrame: begin
                    if (r_cnt == CtrW'(BitLen - 1)) begin
                        r_cnt <= '0;
                        if (r_bit == BitW'(FRAME_W - 1)) begin
                            r_state   <= (r_state == StFrame) ? StGap : StFinalGap;
                            r_sync    <= 1'b1;
                            r_clk_out <= 1'b0;
                            r_din     <= 1'b0;
                        end else begin
                            r_bit     <= r_bit + 1'b1;
                            r_clk_out <= 1'b1;
                            r_din     <= r_sreg[FRAME_W-1];
                            r_sreg    <= r_sreg << 1;
                        end
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_clk_out <= (r_cnt < CtrW'(CLK_DIV - 1));
                    end
                end
                StFinalGap: begin
                    if (w_gap_end) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_clk_out  = r_clk_out;
    assign o_sync_out = r_sync;
    assign o_din      = r_din;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_us_burst_dac_drv.sv
// Directed bench for us_burst_dac_drv: decodes serial frames at clk_out falling edges and
// compares them, plus timing and control behaviour, against hand-computed values.
module tb_us_burst_dac_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [23:0] freq_word;
    logic [15:0] n_cycles;
    logic [2:0]  amp_shift;
    logic        clk_out;
    logic        sync_out;
    logic        din;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    us_burst_dac_drv dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_freq_word(freq_word),
        .i_n_cycles (n_cycles),
        .i_amp_shift(amp_shift),
        .o_clk_out  (clk_out),
        .o_sync_out (sync_out),
        .o_din      (din),
        .o_busy     (busy),
        .o_done     (done)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [15:0] frames[$];
    int          frames_started = 0;
    int          done_cnt       = 0;
    int          first_low      = 0;
    int          fc3_len        = 0;
    int          gap0           = 0;
    logic [63:0] din_tr         = '0;
    logic [63:0] clk_tr         = '0;
    int          t_raise        = 0;
    int          t_sample       = 0;

    // Sine samples at 1/8-turn steps, amp_shift 0 and 3.
    logic [11:0] pat_a [8] = '{12'h800, 12'hDA7, 12'hFFF, 12'hDA7,
                               12'h800, 12'h259, 12'h001, 12'h259};
    logic [11:0] pat_s [8] = '{12'h800, 12'h8B4, 12'h8FF, 12'h8B4,
                               12'h800, 12'h74B, 12'h700, 12'h74B};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : mon
        logic        prev_sync = 1'b1;
        logic        prev_clk  = 1'b0;
        logic [15:0] word      = '0;
        int          fc        = 0;
        int          gc        = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!sync_out) begin
                if (prev_sync) begin
                    if (frames_started == 1) gap0 = gc;
                    frames_started++;
                    if (frames_started == 1) first_low = cyc;
                    word = '0;
                    fc   = 0;
                end
                if (prev_clk && !clk_out) word = {word[14:0], din};
                if (frames_started == 3 && fc < 64) begin
                    din_tr[fc] = din;
                    clk_tr[fc] = clk_out;
                end
                fc++;
            end else begin
                if (!prev_sync) begin
                    frames.push_back(word);
                    if (frames_started == 3) fc3_len = fc;
                    gc = 0;
                end
                gc++;
            end
            prev_sync = sync_out;
            prev_clk  = clk_out;
        end
    end

    task automatic clear_mon();
        frames.delete();
        frames_started = 0;
    endtask

    task automatic start_burst(input logic [23:0] fw, input logic [15:0] nc, input logic [2:0] sh);
        @(posedge clk);
        #1;
        freq_word = fw;
        n_cycles  = nc;
        amp_shift = sh;
        start     = 1'b1;
        t_raise   = cyc;
        @(posedge clk);
        #1;
        t_sample = cyc;
        start    = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or when the budget runs out).
    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, "_done_seen"}, done, 1);
    endtask

    task automatic check_burst(input string tag, input logic [11:0] pat [8], input int n_data);
        logic [15:0] got;
        check_eq({tag, "_nframes"}, frames.size(), n_data + 1);
        for (int i = 0; i <= n_data; i++) begin
            logic [11:0] s;
            s   = (i < n_data) ? pat[i % 8] : 12'h800;
            got = (i < frames.size()) ? frames[i] : 16'hxxxx;
            check_eq($sformatf("%s_f%0d", tag, i), got, {2'b00, s, 2'b00});
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          d0;
        int          i;
        logic [63:0] exp_din;
        logic [63:0] exp_clk;

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        freq_word = '0;
        n_cycles  = '0;
        amp_shift = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_clk_out", clk_out, 0);
        check_eq("rst_sync", sync_out, 1);
        check_eq("rst_din", din, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;

        // Two sine periods at 1/8-turn steps.
        clear_mon();
        start_burst(24'h200000, 16'd2, 3'd0);
        check_eq("busy_after_start", busy, 1);
        wait_done("b1", 3000);
        check_eq("b1_done_latency", cyc - t_sample, 17 * 68 + 2);
        check_eq("b1_busy_at_done", busy, 0);
        repeat (4) @(negedge clk);
        check_eq("b1_sync_latency", first_low - t_raise, 3);
        check_burst("b1", pat_a, 16);

        // Bit timing of the 0xFFF frame (third frame of the burst above).
        for (int j = 0; j < 64; j++) begin
            exp_din[j] = ((j / 4) >= 2) && ((j / 4) <= 13);
            exp_clk[j] = (j % 4) < 2;
        end
        check_eq("bit_din_trace", din_tr, exp_din);
        check_eq("bit_clk_trace", clk_tr, exp_clk);
        check_eq("frame_len", fc3_len, 64);
        check_eq("gap_len", gap0, 4);

        // Attenuated burst; start raised in the done cycle must be ignored.
        clear_mon();
        start_burst(24'h200000, 16'd2, 3'd3);
        wait_done("b2", 3000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_at_done_ignored", busy, 0);
        repeat (4) @(negedge clk);
        check_burst("b2", pat_s, 16);

        // Zero cycles: midscale frame only; restart attempt while busy is ignored.
        clear_mon();
        d0 = done_cnt;
        start_burst(24'h200000, 16'd0, 3'd0);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b3_busy_after_restart", busy, 1);
        wait_done("b3", 500);
        repeat (100) @(negedge clk);
        check_eq("b3_done_count", done_cnt - d0, 1);
        check_eq("b3_busy_idle", busy, 0);
        check_burst("b3", pat_a, 0);

        // Stop during data frame index 5.
        clear_mon();
        start_burst(24'h200000, 16'd2, 3'd0);
        i = 0;
        while (frames_started < 6 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check_eq("b4_reached_frame5", frames_started >= 6, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("b4", 1000);
        repeat (4) @(negedge clk);
        check_burst("b4", pat_a, 6);

        // Reset mid-frame, then a clean burst.
        clear_mon();
        start_burst(24'h200000, 16'd2, 3'd0);
        i = 0;
        while (frames_started < 3 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        repeat (10) @(negedge clk);
        check_eq("b5_mid_frame", sync_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("b5_rst_sync", sync_out, 1);
        check_eq("b5_rst_clk_out", clk_out, 0);
        check_eq("b5_rst_din", din, 0);
        check_eq("b5_rst_busy", busy, 0);
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        check_eq("b5_no_done", done_cnt - d0, 0);
        check_eq("b5_sync_idle", sync_out, 1);
        clear_mon();
        start_burst(24'h200000, 16'd1, 3'd0);
        wait_done("b6", 2000);
        repeat (4) @(negedge clk);
        check_burst("b6", pat_a, 8);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
